rv_imm_gen_stage: RTL

Parametrised, registered immediate-generation stage for the decode pipeline. Accepts a 32-bit instruction word with a valid/ready handshake, classifies its format, and produces an XLEN-wide sign- or zero-extended immediate. The output is registered behind an optional 2-entry skid buffer. It sits between instruction fetch/IR and the decode/execute register, and supports RV32/RV64, correct shift-amount handling and CSR immediates.

---
 rtl/rv_imm_gen_stage_pkg.sv | 75 +++++++
 rtl/rv_imm_gen_stage_if.sv | 32 +++
 rtl/rv_imm_gen_stage_skid.sv | 74 +++++++
 rtl/rv_imm_gen_stage.sv | 46 ++++
 4 files changed

// File: rtl/rv_imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: opcode map, format codes,
// skid-buffer state encoding and the combinational immediate decoder.
package rv_imm_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,
      FMT_SH   = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      SB_EMPTY = 2'd0,
      SB_ONE   = 2'd1,
      SB_FULL  = 2'd2
   } sb_state_e;

   typedef struct packed {
      fmt_e        fmt;
      logic [63:0] imm;
   } dec_t;

   // Immediate is always built at 64 bits; RV32 users keep the low half,
   // which is already the correct 32-bit sign/zero extension.
   function automatic dec_t imm_decode(input logic [31:0] ir,
                                       input logic        xlen64,
                                       input logic        en_csr);
      dec_t       d;
      logic [2:0] f3;
      f3    = ir[14:12];
      d.fmt = FMT_NONE;
      d.imm = '0;
      case (ir[6:0])
         OPC_OP_IMM:                        d.fmt = (f3[1:0] == 2'b01) ? FMT_SH : FMT_I;
         OPC_OP_IMM_32:                     if (xlen64) d.fmt = (f3[1:0] == 2'b01) ? FMT_SH : FMT_I;
         OPC_LOAD, OPC_JALR, OPC_MISC_MEM:  d.fmt = FMT_I;
         OPC_STORE:                         d.fmt = FMT_S;
         OPC_BRANCH:                        d.fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                d.fmt = FMT_U;
         OPC_JAL:                           d.fmt = FMT_J;
         OPC_SYSTEM:                        d.fmt = (en_csr && f3[2]) ? FMT_Z : FMT_I;
         default:                           d.fmt = FMT_NONE;
      endcase
      case (d.fmt)
         FMT_I:  d.imm = {{52{ir[31]}}, ir[31:20]};
         FMT_S:  d.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
         FMT_B:  d.imm = {{52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         FMT_U:  d.imm = {{32{ir[31]}}, ir[31:12], 12'b0};
         FMT_J:  d.imm = {{44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         FMT_Z:  d.imm = {59'b0, ir[19:15]};
         // Only 64-bit OP-IMM shifts own a 6-bit shamt; funct7 never reaches the immediate.
         FMT_SH: d.imm = (xlen64 && ir[6:0] == OPC_OP_IMM) ? {58'b0, ir[25:20]}
                                                           : {59'b0, ir[24:20]};
         default: d.imm = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rv_imm_gen_stage_if.sv
// Upstream/downstream bundle of the immediate-generation stage.
interface rv_imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   import rv_imm_pkg::*;

   // Both sides: a beat transfers on a rising edge where valid & ready are
   // both high; valid may not depend on ready, and a producer holding valid
   // keeps its payload stable until the transfer.
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_ir;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   fmt_e             out_fmt;
   logic [31:0]      out_ir;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_ir, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_ir, out_tag
   );

   modport slave (
      input  in_valid, in_ir, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_ir, out_tag
   );

endinterface

// File: rtl/rv_imm_gen_stage_skid.sv
// Generic 2-entry valid/ready buffer: main entry drives the output, the skid
// entry absorbs one beat of backpressure so in_ready can be registered.
module rv_skid_buf
   import rv_imm_pkg::*;
#(
   parameter int W    = 8,
   parameter bit SKID = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output sb_state_e    dbg_state
);

   sb_state_e    state_q, state_d;
   logic         push, pop;
   logic         load_main, load_skid, main_from_skid;
   logic [W-1:0] main_q, skid_q;

   // With SKID the ready depends only on registered state, never on out_ready.
   assign in_ready  = rst_n & (SKID ? (state_q != SB_FULL)
                                    : (state_q == SB_EMPTY || out_ready));
   assign out_valid = (state_q != SB_EMPTY);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;
   assign out_data  = main_q;
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= SB_EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = SB_EMPTY;
      end else begin
         case (state_q)
            SB_EMPTY: if (push) state_d = SB_ONE;
            SB_ONE: begin
               if (push && !pop)      state_d = SB_FULL;
               else if (!push && pop) state_d = SB_EMPTY;
            end
            SB_FULL:  if (pop) state_d = SB_ONE;
            default:  state_d = SB_EMPTY;
         endcase
      end
   end

   always_comb begin
      load_main      = push && (state_q == SB_EMPTY || (state_q == SB_ONE && pop));
      load_skid      = push && state_q == SB_ONE && !pop;
      main_from_skid = pop && state_q == SB_FULL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)           main_q <= in_data;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_data;
      end
   end

endmodule

// File: rtl/rv_imm_gen_stage.sv
// Registered immediate-generation stage: decode on the input side, then hold
// {imm, fmt, ir, tag} in a 2-entry (or single) valid/ready buffer.
module rv_imm_gen_stage
   import rv_imm_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter bit EN_CSR = 1'b1,
   parameter bit SKID   = 1'b1,
   parameter int TAG_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   rv_imm_gen_stage_if.slave  io,
   output sb_state_e          dbg_state
);

   localparam int PW = XLEN + 3 + 32 + TAG_W;

   dec_t          dec;
   logic [PW-1:0] in_data, out_data;
   logic          unused_imm_hi;

   assign dec           = imm_decode(io.in_ir, XLEN == 64, EN_CSR);
   assign unused_imm_hi = ^dec.imm;
   assign in_data       = {dec.imm[XLEN-1:0], dec.fmt, io.in_ir, io.in_tag};

   rv_skid_buf #(.W(PW), .SKID(SKID)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (io.in_valid),
      .in_ready  (io.in_ready),
      .in_data   (in_data),
      .out_valid (io.out_valid),
      .out_ready (io.out_ready),
      .out_data  (out_data),
      .dbg_state (dbg_state)
   );

   assign io.out_imm = out_data[PW-1 -: XLEN];
   assign io.out_fmt = fmt_e'(out_data[32+TAG_W+2 -: 3]);
   assign io.out_ir  = out_data[32+TAG_W-1 -: 32];
   assign io.out_tag = out_data[TAG_W-1:0];

endmodule
